ads1675_rx: RTL and testbench
=============================

ADS1675_RX -- requirements
Module: ads1675_rx

Interface
REQ-001 Parameter FRAME_W, default 48: sclk periods per ADS1675 conversion frame.
REQ-002 Parameter DATA_W, default 24: conversion word width, two's complement, MSB first.
REQ-003 Parameter TIMEOUT, default 64: clk cycles with no sclk falling edge before a frame is aborted.
REQ-004 Port clk, input, 1: single system clock; all logic is on posedge clk and clk SHALL be at least 4x sclk frequency.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port en, input, 1: receiver enable.
REQ-007 Port sclk_in, input, 1: ADC serial clock, single-ended after the top-level IBUFDS, asynchronous to clk.
REQ-008 Port drdy_in, input, 1: ADC data-ready, single-ended, asynchronous to clk.
REQ-009 Port dout_in, input, 1: ADC serial data, single-ended, asynchronous; the transmitter changes it on sclk rising edges.
REQ-010 Port data_out, output, DATA_W, signed: last captured conversion word.
REQ-011 Port data_valid, output, 1: one-clk pulse, data_out updated.
REQ-012 Port frame_err, output, 1: one-clk pulse, frame aborted.
REQ-013 Port err_cnt, output, 8: saturating count of aborted frames.

Function
REQ-014 sclk_in, drdy_in and dout_in SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals only.
REQ-015 dout SHALL be sampled only on clk cycles where a synchronized sclk falling edge is detected, because data is stable mid-period.
REQ-016 FSM states: IDLE, SHIFT, DONE.
REQ-017 IDLE -> SHIFT on a synchronized drdy rising edge while en=1; bit counter cleared; timeout counter cleared.
REQ-018 In SHIFT, each sclk falling edge SHALL shift dout into the LSB of a DATA_W shift register and increment the bit counter; the first bit captured is the MSB.
REQ-019 SHIFT -> DONE in the cycle where the DATA_W-th bit is captured.
REQ-020 DONE: data_out <= shift register and data_valid=1 for exactly that cycle; next state IDLE; latency is 1 clk after the DATA_W-th sampling edge.
REQ-021 Remaining FRAME_W-DATA_W trailing bits SHALL be ignored; only a new drdy rising edge starts the next frame.
REQ-022 In SHIFT, a drdy rising edge SHALL pulse frame_err, increment err_cnt, and restart SHIFT with counters cleared; this new frame is captured.
REQ-023 In SHIFT, TIMEOUT consecutive clk cycles without an sclk falling edge SHALL pulse frame_err, increment err_cnt, and go to IDLE.
REQ-024 err_cnt SHALL saturate at 255 and not wrap.
REQ-025 en=0 SHALL force IDLE in the next cycle with no data_valid or frame_err; data_out and err_cnt are held.
REQ-026 data_valid and frame_err SHALL never both be asserted in the same cycle.
REQ-027 If a drdy rising edge coincides with the DATA_W-th sampling edge, the word SHALL complete normally and the new drdy SHALL be ignored.

Reset
REQ-028 When rst=1 at a posedge clk: state=IDLE; data_out=0; data_valid=0; frame_err=0; err_cnt=0; shift register, bit counter, timeout counter and synchronizer flops=0. This applies mid-frame as well; a partial word is discarded.

Structure
REQ-029 The shared package ads1675_pkg SHALL hold the FSM state enum type and the localparams ADS1675_FRAME_W=48 and ADS1675_DATA_W=24, which are also used by the ADC model.
REQ-030 One sub-module, ads1675_sync_edge (2-flop synchronizer plus rise/fall detect, 1 bit), SHALL be instantiated three times; all other logic is in ads1675_rx.

Verification
REQ-031 The bench SHALL drive the ADS1675 behavioural model with sclk = clk/8 and data_trans=24'h7FFFFF; required response: one data_valid with data_out=8388607 per frame and no frame_err.
REQ-032 With data_trans=24'h800000 then 24'h000001, data_out SHALL be -8388608 and then 1 on consecutive data_valid pulses.
REQ-033 Injecting a drdy rising edge after 10 bits SHALL produce frame_err and err_cnt=1; the following 24 bits SHALL yield a correct data_valid.
REQ-034 Stopping sclk after 5 bits for 100 clk SHALL pulse frame_err once, with no data_valid, and the FSM SHALL return to IDLE.
REQ-035 Asserting rst after 12 bits, then resuming, SHALL clear all outputs to 0; the next full frame SHALL be captured correctly.
REQ-036 Holding en=0 for two frames SHALL produce no pulses; after en=1 the next frame SHALL be received.

Source files
------------

// File: rtl/ads1675_pkg.sv
// Shared definitions for the ADS1675 serial receiver and its ADC model.
//   state_t          : receiver FSM states
//   ADS1675_FRAME_W  : sclk periods per conversion frame
//   ADS1675_DATA_W   : conversion word width (two's complement, MSB first)
package ads1675_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ADS1675_FRAME_W = 48;
  localparam int ADS1675_DATA_W  = 24;

endpackage

// File: rtl/ads1675_sync_edge.sv
// Two-flop synchronizer for one asynchronous bit, with rise/fall detection
// performed on the synchronized value only.
//   clk   : system clock
//   rst   : synchronous active-high reset, clears all flops
//   din   : asynchronous input
//   level : synchronized level
//   rise  : one-clk pulse on a synchronized 0->1 transition
//   fall  : one-clk pulse on a synchronized 1->0 transition
module ads1675_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  // stage 0/1: metastability filter; stage 2: previous value for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      meta_p0 <= din;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~prev_p2;
  assign fall  = ~sync_p1 & prev_p2;

endmodule

// File: rtl/ads1675_rx.sv
// ADS1675 serial conversion-frame receiver. A synchronized drdy rising edge
// starts a frame; dout is sampled on synchronized sclk falling edges, MSB
// first, and the DATA_W-th bit completes the word. Trailing frame bits are
// ignored. A new drdy edge mid-word or an sclk stall aborts the frame.
//   clk        : system clock (>= 4x sclk)
//   rst        : synchronous active-high reset
//   en         : receiver enable; low forces IDLE
//   sclk_in    : ADC serial clock (asynchronous)
//   drdy_in    : ADC data ready (asynchronous)
//   dout_in    : ADC serial data (asynchronous, changes on sclk rise)
//   data_out   : last captured conversion word (signed)
//   data_valid : one-clk pulse when data_out has been updated
//   frame_err  : one-clk pulse when a frame is aborted
//   err_cnt    : saturating count of aborted frames
module ads1675_rx
  import ads1675_pkg::*;
#(
  parameter int FRAME_W = ADS1675_FRAME_W,
  parameter int DATA_W  = ADS1675_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     sclk_in,
  input  logic                     drdy_in,
  input  logic                     dout_in,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     data_valid,
  output logic                     frame_err,
  output logic [7:0]               err_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  if (FRAME_W < DATA_W) begin : g_bad_frame
    $error("ads1675_rx: FRAME_W must not be smaller than DATA_W");
  end

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic drdy_lvl, drdy_rise, drdy_fall;
  logic dout_lvl, dout_rise, dout_fall;
  logic unused_sync;

  ads1675_sync_edge u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk_in),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  ads1675_sync_edge u_sync_drdy (
    .clk   (clk),
    .rst   (rst),
    .din   (drdy_in),
    .level (drdy_lvl),
    .rise  (drdy_rise),
    .fall  (drdy_fall)
  );

  ads1675_sync_edge u_sync_dout (
    .clk   (clk),
    .rst   (rst),
    .din   (dout_in),
    .level (dout_lvl),
    .rise  (dout_rise),
    .fall  (dout_fall)
  );

  assign unused_sync = ^{sclk_lvl, sclk_rise, drdy_lvl, drdy_fall, dout_rise, dout_fall};

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              capture;
  logic              clear;
  logic              tmo_inc;
  logic              abort;
  logic              finish;

  // dout and sclk share the same synchronizer depth, so dout_lvl is the
  // value that was on the line around the sclk falling edge.
  assign shreg_nxt = {shreg[DATA_W-2:0], dout_lvl};

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    clear     = 1'b0;
    tmo_inc   = 1'b0;
    abort     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (en && drdy_rise) begin
          state_nxt = SHIFT;
          clear     = 1'b1;
        end
      end
      SHIFT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (sclk_fall && bit_cnt == LAST_BIT) begin
          // final bit wins over a coincident drdy edge
          capture   = 1'b1;
          finish    = 1'b1;
          state_nxt = DONE;
        end else if (drdy_rise) begin
          abort = 1'b1;
          clear = 1'b1;
        end else if (sclk_fall) begin
          capture = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // registered control, data and output pulses; data_valid is high while in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      state      <= state_nxt;
      data_valid <= finish;
      frame_err  <= abort;
      if (abort) begin
        err_cnt <= sat_inc8(err_cnt);
      end
      if (clear) begin
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else if (capture) begin
        shreg   <= shreg_nxt;
        bit_cnt <= bit_cnt + CNT_W'(1);
        tmo_cnt <= '0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (finish) begin
        data_out <= shreg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ads1675_rx.sv
// Directed bench for ads1675_rx with a behavioural ADS1675 frame generator
// (sclk = clk/8, dout changes on sclk rising edges).
module tb_ads1675_rx;
  import ads1675_pkg::*;

  localparam int DW = ADS1675_DATA_W;
  localparam int FW = ADS1675_FRAME_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 sclk_in;
  logic                 drdy_in;
  logic                 dout_in;
  logic signed [DW-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic [7:0]           err_cnt;

  always #5 clk = ~clk;

  ads1675_rx dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sclk_in    (sclk_in),
    .drdy_in    (drdy_in),
    .dout_in    (dout_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int nv       = 0;
  int nfe      = 0;
  int nboth    = 0;
  int last_val = 0;

  always @(negedge clk) begin
    if (data_valid) begin
      nv       <= nv + 1;
      last_val <= int'(data_out);
    end
    if (frame_err) nfe <= nfe + 1;
    if (data_valid && frame_err) nboth <= nboth + 1;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation still running at 60000 cycles, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One ADC frame: drdy rises, then nbits sclk periods. Optionally raise a
  // fresh drdy exactly on the DW-th falling edge.
  task automatic frame(input logic [DW-1:0] w, input int nbits, input bit coinc);
    drdy_in = 1'b0;
    wclk(4);
    drdy_in = 1'b1;
    wclk(8);
    for (int i = 0; i < nbits; i++) begin
      sclk_in = 1'b1;
      dout_in = (i < DW) ? w[DW-1-i] : 1'b0;
      if (i == 2) drdy_in = 1'b0;
      wclk(4);
      sclk_in = 1'b0;
      if (coinc && i == DW - 1) drdy_in = 1'b1;
      wclk(4);
    end
  endtask

  task automatic bare_clocks(input int n);
    for (int i = 0; i < n; i++) begin
      sclk_in = 1'b1;
      dout_in = 1'b1;
      wclk(4);
      sclk_in = 1'b0;
      wclk(4);
    end
  endtask

  typedef struct {
    logic [DW-1:0] word;
    int            exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int v0, f0;
    vecs[0] = '{24'h7FFFFF, 8388607};
    vecs[1] = '{24'h800000, -8388608};
    vecs[2] = '{24'h000001, 1};
    vecs[3] = '{24'hFFFFFF, -1};
    vecs[4] = '{24'hA5A5A5, -5921371};
    vecs[5] = '{24'h000000, 0};
    vecs[6] = '{24'h123456, 1193046};

    rst = 1'b1; en = 1'b0; sclk_in = 1'b0; drdy_in = 1'b0; dout_in = 1'b0;
    wclk(4);
    check("rst_data_out", int'(data_out), 0);
    check("rst_valid", int'(data_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    rst = 1'b0;
    en  = 1'b1;
    wclk(4);

    // table of full frames
    for (int k = 0; k < 7; k++) begin
      v0 = nv; f0 = nfe;
      frame(vecs[k].word, FW, 1'b0);
      wclk(4);
      check($sformatf("vec%0d_valid_cnt", k), nv - v0, 1);
      check($sformatf("vec%0d_data", k), last_val, vecs[k].exp);
      check($sformatf("vec%0d_no_err", k), nfe - f0, 0);
    end
    check("table_err_cnt", int'(err_cnt), 0);

    // drdy restart after 10 bits; the restarted frame is captured
    v0 = nv; f0 = nfe;
    frame(24'h0F0F0F, 10, 1'b0);
    frame(24'h3C3C3C, FW, 1'b0);
    wclk(4);
    check("restart_err_pulses", nfe - f0, 1);
    check("restart_err_cnt", int'(err_cnt), 1);
    check("restart_valid_cnt", nv - v0, 1);
    check("restart_data", last_val, 32'h003C3C3C);

    // sclk stall after 5 bits
    v0 = nv; f0 = nfe;
    frame(24'h555555, 5, 1'b0);
    wclk(100);
    check("stall_err_pulses", nfe - f0, 1);
    check("stall_no_valid", nv - v0, 0);
    check("stall_err_cnt", int'(err_cnt), 2);
    check("stall_idle", int'(dut.state), int'(IDLE));
    frame(24'h654321, FW, 1'b0);
    wclk(4);
    check("stall_recover_data", last_val, 32'h00654321);
    check("stall_recover_valid", nv - v0, 1);

    // drdy edge coincident with the last data bit
    v0 = nv; f0 = nfe;
    frame(24'hC00003, FW, 1'b1);
    wclk(80);
    check("coinc_valid_cnt", nv - v0, 1);
    check("coinc_data", last_val, -4194301);
    check("coinc_no_err", nfe - f0, 0);

    // reset in the middle of a frame
    frame(24'hFEDCBA, 12, 1'b0);
    rst = 1'b1;
    wclk(2);
    rst = 1'b0;
    wclk(1);
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_err_cnt", int'(err_cnt), 0);
    check("midrst_valid", int'(data_valid), 0);
    check("midrst_frame_err", int'(frame_err), 0);
    v0 = nv; f0 = nfe;
    bare_clocks(FW - 12);
    check("midrst_tail_ignored", nv - v0, 0);
    frame(24'h400000, FW, 1'b0);
    wclk(4);
    check("midrst_next_valid", nv - v0, 1);
    check("midrst_next_data", last_val, 4194304);
    check("midrst_next_no_err", nfe - f0, 0);

    // disabled for two frames
    en = 1'b0;
    v0 = nv; f0 = nfe;
    frame(24'h111111, FW, 1'b0);
    frame(24'h222222, FW, 1'b0);
    wclk(4);
    check("dis_no_valid", nv - v0, 0);
    check("dis_no_err", nfe - f0, 0);
    check("dis_data_held", int'(data_out), 4194304);
    en = 1'b1;
    wclk(2);
    frame(24'h333333, FW, 1'b0);
    wclk(4);
    check("en_valid", nv - v0, 1);
    check("en_data", last_val, 32'h00333333);

    // err_cnt saturation: first rise enters SHIFT, the next 259 abort
    f0 = nfe;
    drdy_in = 1'b0;
    wclk(4);
    for (int i = 0; i < 260; i++) begin
      drdy_in = 1'b1;
      wclk(4);
      drdy_in = 1'b0;
      wclk(4);
    end
    check("sat_err_pulses", nfe - f0, 259);
    check("sat_err_cnt", int'(err_cnt), 255);
    v0 = nv;
    frame(24'h0000FF, FW, 1'b0);
    wclk(4);
    check("sat_hold_err_cnt", int'(err_cnt), 255);
    check("sat_frame_valid", nv - v0, 1);
    check("sat_frame_data", last_val, 255);

    check("never_both_pulses", nboth, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
